// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential bit-slice ALU controller.
package alu_pkg;

  localparam int unsigned OPSEL_W = 3;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Control fields latched at request acceptance
  typedef struct packed {
    logic [OPSEL_W-1:0] opsel;
    logic               mode;
    logic               cin;
  } alu_ctl_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequences a word-wide ALU operation through one external ALU slice, LSB slice first.
// Optional overflow reporting is enabled with `define ALU_SEQ_OVF_EN.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NSLICE  = 4,
  parameter int unsigned SLICE_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [OPSEL_W-1:0]          req_opsel,
  input  logic                        req_mode,
  input  logic [NSLICE*SLICE_W-1:0]   req_a,
  input  logic [NSLICE*SLICE_W-1:0]   req_b,
  input  logic                        Cin_initial,
  output logic [OPSEL_W-1:0]          opsel,
  output logic                        mode,
  output logic                        carry_in,
  output logic [SLICE_W-1:0]          slice_a,
  output logic [SLICE_W-1:0]          slice_b,
  input  logic [SLICE_W-1:0]          slice_y,
  input  logic                        slice_cout,
`ifdef ALU_SEQ_OVF_EN
  input  logic                        slice_ovf,
  output logic                        rsp_ovf,
`endif
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [NSLICE*SLICE_W-1:0]   rsp_y,
  output logic                        rsp_cout,
  output logic                        rsp_zero
);

  localparam int unsigned WORD_W = NSLICE * SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  alu_ctl_t           r_ctl;
  logic [WORD_W-1:0]  r_a;
  logic [WORD_W-1:0]  r_b;
  logic [WORD_W-1:0]  r_y;
  logic [WORD_W-1:0]  w_y_nxt;
  logic               r_carry;
  logic               r_cout;
  logic               r_zero;
  logic               r_valid;
  logic               r_ready;
  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic [SLICE_W-1:0] w_slice_a;
  logic [SLICE_W-1:0] w_slice_b;

  // r_ready mirrors IDLE, so acceptance can only happen from IDLE
  assign w_accept = req_valid & r_ready;
  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state and slice index sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
        end
      end
      RUN: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = DONE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Operand slice select and result slice insert for the current index
  always_comb begin
    w_slice_a = '0;
    w_slice_b = '0;
    w_y_nxt   = r_y;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_slice_a                      = r_a[i*SLICE_W +: SLICE_W];
        w_slice_b                      = r_b[i*SLICE_W +: SLICE_W];
        w_y_nxt[i*SLICE_W +: SLICE_W]  = slice_y;
      end
    end
  end

  // Request latch, per-slice capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_ctl   <= '{opsel: req_opsel, mode: req_mode, cin: Cin_initial};
        r_a     <= req_a;
        r_b     <= req_b;
        r_y     <= '0;
        r_carry <= 1'b0;
        r_cout  <= 1'b0;
        r_zero  <= 1'b0;
      end else if (w_run) begin
        r_y     <= w_y_nxt;
        r_carry <= slice_cout;
        if (w_last) begin
          r_cout <= (r_ctl.mode == MODE_ARITH) & slice_cout;
          r_zero <= (w_y_nxt == '0);
        end
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic r_ovf;

  // Overflow is meaningful only on the most significant slice of an arithmetic op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_ctl.mode == MODE_ARITH) & slice_ovf;
    end
  end

  assign rsp_ovf = r_ovf;
`endif

  // Slice drive is idle-zero outside RUN; logic mode never propagates carry
  assign opsel    = w_run ? r_ctl.opsel : '0;
  assign mode     = w_run & r_ctl.mode;
  assign slice_a  = w_run ? w_slice_a : '0;
  assign slice_b  = w_run ? w_slice_b : '0;
  assign carry_in = w_run & (r_ctl.mode == MODE_ARITH) &
                    ((r_idx == '0) ? r_ctl.cin : r_carry);

  assign req_ready = r_ready;
  assign rsp_valid = r_valid;
  assign rsp_y     = r_y;
  assign rsp_cout  = r_cout;
  assign rsp_zero  = r_zero;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU slice plus a word-level reference model.
module tb_alu_seq_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned WW = N * W;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_opsel;
  logic          req_mode;
  logic [WW-1:0] req_a;
  logic [WW-1:0] req_b;
  logic          Cin_initial;
  logic [2:0]    opsel;
  logic          mode;
  logic          carry_in;
  logic [W-1:0]  slice_a;
  logic [W-1:0]  slice_b;
  logic [W-1:0]  slice_y;
  logic          slice_cout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [WW-1:0] rsp_y;
  logic          rsp_cout;
  logic          rsp_zero;
`ifdef ALU_SEQ_OVF_EN
  logic          slice_ovf;
  logic          rsp_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_ctrl #(.NSLICE(N), .SLICE_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opsel   (req_opsel),
    .req_mode    (req_mode),
    .req_a       (req_a),
    .req_b       (req_b),
    .Cin_initial (Cin_initial),
    .opsel       (opsel),
    .mode        (mode),
    .carry_in    (carry_in),
    .slice_a     (slice_a),
    .slice_b     (slice_b),
    .slice_y     (slice_y),
    .slice_cout  (slice_cout),
`ifdef ALU_SEQ_OVF_EN
    .slice_ovf   (slice_ovf),
    .rsp_ovf     (rsp_ovf),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_y       (rsp_y),
    .rsp_cout    (rsp_cout),
    .rsp_zero    (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU slice: add/sub in arithmetic mode; bitwise ops with a junk cout in logic mode
  logic [W-1:0] w_bb;
  always_comb begin
    w_bb = opsel[0] ? ~slice_b : slice_b;
    slice_y    = '0;
    slice_cout = 1'b0;
    if (mode == 1'b0) begin
      {slice_cout, slice_y} = 9'(slice_a) + 9'(w_bb) + 9'(carry_in);
    end else begin
      slice_cout = 1'b1;
      case (opsel[1:0])
        2'd0:    slice_y = slice_a & slice_b;
        2'd1:    slice_y = slice_a | slice_b;
        2'd2:    slice_y = slice_a ^ slice_b;
        default: slice_y = ~(slice_a | slice_b);
      endcase
    end
  end

  // Whole-word reference: {cout, y}
  function automatic logic [WW:0] ref_word(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                           input logic [2:0] op, input logic md, input logic cin);
    logic [WW-1:0] bb;
    logic [WW-1:0] y;
    bb = op[0] ? ~b : b;
    if (md == 1'b0) return (WW+1)'(a) + (WW+1)'(bb) + (WW+1)'(cin);
    case (op[1:0])
      2'd0:    y = a & b;
      2'd1:    y = a | b;
      2'd2:    y = a ^ b;
      default: y = ~(a | b);
    endcase
    return {1'b0, y};
  endfunction

  // Carry into slice k = carry out of the sum of the k lower slices
  function automatic logic ref_cin(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                   input logic [2:0] op, input logic md, input logic cin,
                                   input int k);
    longint unsigned mask;
    longint unsigned sum;
    logic [WW-1:0]   bb;
    if (md) return 1'b0;
    if (k == 0) return cin;
    bb   = op[0] ? ~b : b;
    mask = (64'd1 << (k * W)) - 64'd1;
    sum  = (64'(a) & mask) + (64'(bb) & mask) + 64'(cin);
    return sum[k*W];
  endfunction

  task automatic exec_op(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic [2:0] op,
                         input logic md, input logic cin, input logic [N-1:0] ovf_mask,
                         input int hold, input bit pend, input string name);
    logic [WW:0]   exp;
    logic [WW-1:0] y_hold;
    logic          exp_ci;
    int            t;
    exp = ref_word(a, b, op, md, cin);
    t = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: req_ready=%b required 1 within 20 cycles", name, req_ready);
      return;
    end
    req_valid = 1'b1; req_a = a; req_b = b; req_opsel = op; req_mode = md; Cin_initial = cin;
    @(posedge clk);
    for (int k = 0; k < int'(N); k++) begin
      @(negedge clk);
      // Changing request inputs mid-operation must not disturb it
      req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
      req_opsel = 3'($urandom); req_mode = 1'($urandom); Cin_initial = 1'($urandom);
      exp_ci = ref_cin(a, b, op, md, cin, k);
      n_checks++;
      if (carry_in !== exp_ci) begin
        n_fail++;
        $display("FAIL %s carry_in slice %0d: got %b required %b", name, k, carry_in, exp_ci);
      end
      n_checks++;
      if (slice_a !== W'(a >> (k * W)) || slice_b !== W'(b >> (k * W))) begin
        n_fail++;
        $display("FAIL %s operands slice %0d: got a=%h b=%h required a=%h b=%h", name, k,
                 slice_a, slice_b, W'(a >> (k * W)), W'(b >> (k * W)));
      end
      n_checks++;
      if (opsel !== op || mode !== md || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s run ctl slice %0d: got opsel=%0d mode=%b valid=%b ready=%b required %0d %b 0 0",
                 name, k, opsel, mode, rsp_valid, req_ready, op, md);
      end
`ifdef ALU_SEQ_OVF_EN
      slice_ovf = ovf_mask[k];
`endif
      @(posedge clk);
    end
    @(negedge clk);
`ifdef ALU_SEQ_OVF_EN
    slice_ovf = 1'b0;
`endif
    if (pend) begin
      req_valid = 1'b1; req_opsel = 3'd5; req_a = $urandom; req_b = $urandom;
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== exp[WW-1:0] || rsp_cout !== exp[WW] ||
        rsp_zero !== (exp[WW-1:0] == '0)) begin
      n_fail++;
      $display("FAIL %s result: got valid=%b y=%h cout=%b zero=%b required 1 %h %b %b", name,
               rsp_valid, rsp_y, rsp_cout, rsp_zero, exp[WW-1:0], exp[WW], exp[WW-1:0] == '0);
    end
    n_checks++;
    if (req_ready !== 1'b0 || opsel !== 3'd0 || mode !== 1'b0 || carry_in !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done idle drive: got ready=%b opsel=%0d mode=%b cin=%b required all 0",
               name, req_ready, opsel, mode, carry_in);
    end
`ifdef ALU_SEQ_OVF_EN
    n_checks++;
    if (rsp_ovf !== (ovf_mask[N-1] & ~md)) begin
      n_fail++;
      $display("FAIL %s rsp_ovf: got %b required %b", name, rsp_ovf, ovf_mask[N-1] & ~md);
    end
`endif
    y_hold = exp[WW-1:0];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== y_hold || rsp_cout !== exp[WW] || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold %0d: got valid=%b y=%h cout=%b ready=%b required 1 %h %b 0",
                 name, h, rsp_valid, rsp_y, rsp_cout, req_ready, y_hold, exp[WW]);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || opsel !== 3'd0) begin
      n_fail++;
      $display("FAIL %s handshake: got valid=%b ready=%b opsel=%0d required 0 1 0", name,
               rsp_valid, req_ready, opsel);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({rsp_valid, rsp_y, rsp_cout, rsp_zero, opsel, mode, carry_in, slice_a, slice_b} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got valid=%b y=%h cout=%b zero=%b opsel=%0d mode=%b cin=%b a=%h b=%h",
               rsp_valid, rsp_y, rsp_cout, rsp_zero, opsel, mode, carry_in, slice_a, slice_b);
    end
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset req_ready: got %b required 0", req_ready);
    end
`ifdef ALU_SEQ_OVF_EN
    n_checks++;
    if (rsp_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset rsp_ovf: got %b required 0", rsp_ovf);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset release: got ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_directed;
    exec_op(32'h0000_00FF, 32'h0000_0001, 3'd0, 1'b0, 1'b0, '0, 0, 1'b0, "add_ff_1");
    exec_op(32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0, 1'b0, '0, 0, 1'b0, "add_wrap");
    exec_op(32'hA5A5_0F0F, 32'h5A5A_FF00, 3'd2, 1'b1, 1'b1, '0, 0, 1'b0, "logic_xor");
    exec_op(32'h1234_5678, 32'h1234_5678, 3'd1, 1'b0, 1'b1, '0, 0, 1'b0, "sub_equal");
  endtask

  task automatic test_back_to_back;
    exec_op(32'h8000_0001, 32'h7FFF_FFFF, 3'd0, 1'b0, 1'b1, '0, 3, 1'b1, "b2b_first");
    exec_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'd1, 1'b1, 1'b0, '0, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_run;
    int  t;
    bit  seen;
    t = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    req_valid = 1'b1; req_a = 32'h1234_5678; req_b = 32'h00FF_00FF;
    req_opsel = 3'd0; req_mode = 1'b0; Cin_initial = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (slice_a !== 8'h34) begin
      n_fail++;
      $display("FAIL midrun slice2 position: got slice_a=%h required 34", slice_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_y, rsp_cout, rsp_zero, opsel, mode, carry_in, slice_a, slice_b, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL midrun async reset: got valid=%b y=%h cout=%b zero=%b opsel=%0d mode=%b cin=%b a=%h b=%h ready=%b",
               rsp_valid, rsp_y, rsp_cout, rsp_zero, opsel, mode, carry_in, slice_a, slice_b, req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun discard: got rsp_valid_seen=%b ready=%b required 0 1", seen, req_ready);
    end
    exec_op(32'hDEAD_BEEF, 32'h2152_4111, 3'd0, 1'b0, 1'b0, '0, 1, 1'b0, "after_reset");
  endtask

  task automatic test_ovf;
    exec_op(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 1'b0, 1'b0, 4'b1000, 0, 1'b0, "ovf_last");
    exec_op(32'h0000_0010, 32'h0000_0020, 3'd0, 1'b0, 1'b0, 4'b0010, 0, 1'b0, "ovf_slice1");
    exec_op(32'h0000_0010, 32'h0000_0020, 3'd1, 1'b1, 1'b0, 4'b1000, 0, 1'b0, "ovf_logic");
  endtask

  task automatic test_random;
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 6 == 0) b = ~a;
      if (i % 7 == 0) b = a;
      exec_op(a, b, 3'($urandom), 1'($urandom), 1'($urandom), N'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom), "random");
    end
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_opsel = '0; req_mode = 1'b0;
    req_a = '0; req_b = '0; Cin_initial = 1'b0; rsp_ready = 1'b0;
`ifdef ALU_SEQ_OVF_EN
    slice_ovf = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_ovf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
